// File: rtl/btn_event.sv
// Button event classifier: turns the debounced level into press/release pulses, a held level and auto-repeat pulses.
// rel/rpt carry the release and repeat pulses; auto-repeat is compiled in only when BTN_EVENT_REPEAT_EN is defined.
module btn_event #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic state,
    output logic press,
    output logic rel,
    output logic held,
    output logic rpt
);

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        PRESSED,
        HELD
    } fsm_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
`ifdef BTN_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

    fsm_t             cur, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             press_nxt, rel_nxt, held_nxt, rpt_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur   <= WAIT_LOW;
            cnt   <= '0;
            press <= 1'b0;
            rel   <= 1'b0;
            held  <= 1'b0;
            rpt   <= 1'b0;
        end else begin
            cur   <= nxt;
            cnt   <= cnt_nxt;
            press <= press_nxt;
            rel   <= rel_nxt;
            held  <= held_nxt;
            rpt   <= rpt_nxt;
        end
    end

    always_comb begin
        nxt       = cur;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        held_nxt  = held;
        rpt_nxt   = 1'b0;
        case (cur)
            WAIT_LOW: begin
                if (!state) begin
                    nxt = IDLE;
                end
            end
            IDLE: begin
                if (state) begin
                    nxt       = PRESSED;
                    press_nxt = 1'b1;
                    cnt_nxt   = '0;
                end
            end
            PRESSED: begin
                if (!state) begin
                    nxt      = IDLE;
                    rel_nxt  = 1'b1;
                    held_nxt = 1'b0;
                    cnt_nxt  = '0;
                end else if (cnt == HOLD_LAST) begin
                    nxt      = HELD;
                    held_nxt = 1'b1;
                    cnt_nxt  = '0;
`ifdef BTN_EVENT_REPEAT_EN
                    rpt_nxt  = 1'b1;
`endif
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                // A release on a repeat terminal count suppresses the repeat.
                if (!state) begin
                    nxt      = IDLE;
                    rel_nxt  = 1'b1;
                    held_nxt = 1'b0;
                    cnt_nxt  = '0;
                end else begin
`ifdef BTN_EVENT_REPEAT_EN
                    if (cnt == REPEAT_LAST) begin
                        rpt_nxt = 1'b1;
                        cnt_nxt = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
`else
                    cnt_nxt = '0;
`endif
                end
            end
            default: begin
                nxt = WAIT_LOW;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event (HOLD=4, REPEAT=3, CNT_W=3): directed vector table, hand sequences and random stimulus vs a reference model.
module tb_btn_event;

    localparam int HOLD = 4;
    localparam int REP  = 3;
`ifdef BTN_EVENT_REPEAT_EN
    localparam bit RE = 1'b1;
`else
    localparam bit RE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic state = 1'b0;
    logic press, rel, held, rpt;

    btn_event #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP),
        .CNT_W        (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .state(state),
        .press(press),
        .rel  (rel),
        .held (held),
        .rpt  (rpt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       state;
        logic [3:0] exp;   // {press, release, held, repeat}
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // reference model: armed flag, button-down flag, edges since the press edge
    bit   m_armed = 0;
    bit   m_down  = 0;
    int   m_age   = 0;
    logic [3:0] m_out = 4'b0000;

    function automatic void model_edge(input logic r, input logic s);
        m_out = 4'b0000;
        if (!r) begin
            m_armed = 0;
            m_down  = 0;
            m_age   = 0;
        end else if (!m_armed) begin
            if (!s) m_armed = 1;
        end else if (!m_down) begin
            if (s) begin
                m_down   = 1;
                m_age    = 0;
                m_out[3] = 1'b1;
            end
        end else if (!s) begin
            m_down   = 0;
            m_out[2] = 1'b1;
        end else begin
            m_age++;
            m_out[1] = (m_age >= HOLD);
            m_out[0] = RE && (m_age >= HOLD) && (((m_age - HOLD) % REP) == 0);
        end
    endfunction

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got {press,rel,held,rpt}=%b expected=%b", name, got, want);
        end
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic r, input logic s);
        @(negedge clk);
        rst_n = r;
        state = s;
        @(posedge clk);
        model_edge(r, s);
        #1;
        check("model", {press, rel, held, rpt}, m_out);
    endtask

    function automatic void add(input logic r, input logic s, input logic [3:0] e);
        vec_t v;
        v.rst_n = r;
        v.state = s;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic s;
        // reset state, then a long hold: held + repeat at edge 4, repeats at 7 and 10
        add(0, 0, 4'b0000);
        add(1, 0, 4'b0000);
        add(1, 1, 4'b1000);
        for (int e = 1; e <= 10; e++)
            add(1, 1, {2'b00, e >= HOLD, RE && (e == 4 || e == 7 || e == 10)});
        add(1, 0, 4'b0100);
        add(1, 0, 4'b0000);
        // short press
        add(1, 1, 4'b1000);
        add(1, 1, 4'b0000);
        add(1, 0, 4'b0100);
        add(1, 0, 4'b0000);
        // drop exactly on the repeat terminal count at edge 7: release wins
        add(1, 1, 4'b1000);
        for (int e = 1; e <= 6; e++)
            add(1, 1, {2'b00, e >= HOLD, RE && (e == 4)});
        add(1, 0, 4'b0100);
        // one-cycle glitch from IDLE
        add(1, 1, 4'b1000);
        add(1, 0, 4'b0100);
        add(1, 0, 4'b0000);
        // button held through reset: nothing until released once
        add(0, 1, 4'b0000);
        add(1, 1, 4'b0000);
        add(1, 1, 4'b0000);
        add(1, 1, 4'b0000);
        add(1, 0, 4'b0000);
        add(1, 1, 4'b1000);
        add(1, 0, 4'b0100);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].state);
            check($sformatf("vec%0d", i), {press, rel, held, rpt}, vecs[i].exp);
        end

        // reset pulsed while in HELD
        step(1, 1); check("hr_press", {press, rel, held, rpt}, 4'b1000);
        for (int e = 1; e <= HOLD; e++) step(1, 1);
        check("hr_held", {press, rel, held, rpt}, {3'b001, RE});
        step(1, 1); check("hr_hold2", {press, rel, held, rpt}, 4'b0010);
        step(0, 1); check("hr_rst", {press, rel, held, rpt}, 4'b0000);
        step(1, 1); check("hr_wait1", {press, rel, held, rpt}, 4'b0000);
        step(1, 1); check("hr_wait2", {press, rel, held, rpt}, 4'b0000);
        step(1, 0); check("hr_arm", {press, rel, held, rpt}, 4'b0000);
        step(1, 1); check("hr_press2", {press, rel, held, rpt}, 4'b1000);
        step(1, 0); check("hr_rel2", {press, rel, held, rpt}, 4'b0100);

        // random stimulus with long runs so holds and repeats occur
        s = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) s = ~s;
            step(($urandom_range(0, 99) != 0), s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

endmodule
